// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and per-boundary payload layouts for pipe_stage_skid.
// Holds FSM encoding, field offsets/widths and derived kill masks.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  localparam int XLEN = 64;

  localparam int WDATA_SRC_LENGTH = 2;
  localparam int WB_SEL_LENGTH    = 2;
  localparam int RD_LENGTH        = 5;
  localparam int FUNCT3_LENGTH    = 3;

  // ID -> EXE payload layout
  localparam int IE_REG_WE     = 0;
  localparam int IE_MEM_WE     = 1;
  localparam int IE_MEM_RE     = 2;
  localparam int IE_WDATA_SRC  = 3;
  localparam int IE_FUNCT3     = IE_WDATA_SRC + WDATA_SRC_LENGTH;
  localparam int IE_RD         = IE_FUNCT3 + FUNCT3_LENGTH;
  localparam int IE_RS1        = IE_RD + RD_LENGTH;
  localparam int IE_RS2        = IE_RS1 + XLEN;
  localparam int IE_IMM        = IE_RS2 + XLEN;
  localparam int IE_PC         = IE_IMM + XLEN;
  localparam int ID_EXE_W      = IE_PC + XLEN;

  // EXE -> MEM payload layout
  localparam int EM_REG_WE     = 0;
  localparam int EM_MEM_WE     = 1;
  localparam int EM_MEM_RE     = 2;
  localparam int EM_WDATA_SRC  = 3;
  localparam int EM_FUNCT3     = EM_WDATA_SRC + WDATA_SRC_LENGTH;
  localparam int EM_RD         = EM_FUNCT3 + FUNCT3_LENGTH;
  localparam int EM_ALU        = EM_RD + RD_LENGTH;
  localparam int EM_STORE      = EM_ALU + XLEN;
  localparam int EXE_MEM_W     = EM_STORE + XLEN;

  // MEM -> WB payload layout
  localparam int MW_REG_WE     = 0;
  localparam int MW_WB_SEL     = 1;
  localparam int MW_RD         = MW_WB_SEL + WB_SEL_LENGTH;
  localparam int MW_RESULT     = MW_RD + RD_LENGTH;
  localparam int MEM_WB_W      = MW_RESULT + XLEN;

  // Side-effect bits that must read 0 whenever the stage is empty.
  localparam logic [ID_EXE_W-1:0] ID_EXE_KILL =
    (ID_EXE_W'(1) << IE_REG_WE) |
    (ID_EXE_W'(1) << IE_MEM_WE) |
    (ID_EXE_W'(1) << IE_MEM_RE);

  localparam logic [EXE_MEM_W-1:0] EXE_MEM_KILL =
    (EXE_MEM_W'(1) << EM_REG_WE) |
    (EXE_MEM_W'(1) << EM_MEM_WE) |
    (EXE_MEM_W'(1) << EM_MEM_RE);

  localparam logic [MEM_WB_W-1:0] MEM_WB_KILL =
    (MEM_WB_W'(1) << MW_REG_WE);

endpackage

// File: rtl/pipe_stage_skid.sv
// Pipeline boundary register with 2-entry skid, flush and stall counter.
// Ports: clk/rst, flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data, stall_cnt.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] KILL_MASK = {DATA_W{1'b0}},
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic accept;
  logic release_ev;
  logic stalled;

  assign out_valid  = (state_q != ST_EMPTY);
  assign in_ready   = in_ready_q;
  assign accept     = in_valid & in_ready_q;
  assign release_ev = out_valid & out_ready;
  assign stalled    = out_valid & ~out_ready;

  assign out_data   = out_valid ? main_q
                                : (main_q & ~KILL_MASK);
  assign stall_cnt  = cnt_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          unique case (1'b1)
            accept & release_ev: begin
              main_d = in_data;
            end
            accept & ~release_ev: begin
              skid_d  = in_data;
              state_d = ST_FULL;
            end
            ~accept & release_ev: begin
              state_d = ST_EMPTY;
            end
            default: ;
          endcase
        end
        ST_FULL: begin
          // in_ready is low here, so only a release can happen.
          if (release_ev) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Registered ready is derived from the next state so it is exact.
  always_comb begin
    in_ready_d = (state_d != ST_FULL);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stalled && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and scoreboarded checks for pipe_stage_skid.
// DUT: DATA_W=8, KILL_MASK=8'h03, CNT_W=4.
module tb_pipe_stage_skid;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] stall_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W   (8),
    .KILL_MASK(8'h03),
    .CNT_W    (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [7:0] q[$];
  int         cnt_m;
  logic       acc;
  logic       rel;

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hAB;
    out_ready = 1'b0;

    // 1: reset with in_valid high
    tick();
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_od", 32'(out_data), 32'h00);
    chk("rst_ir", 32'(in_ready), 32'd1);
    chk("rst_sc", 32'(stall_cnt), 32'd0);

    // 2: streaming
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h11 + 8'(i);
      chk("str_ir", 32'(in_ready), 32'd1);
      tick();
      chk("str_ov", 32'(out_valid), 32'd1);
      chk("str_od", 32'(out_data), 32'(8'h11 + 8'(i)));
    end
    in_valid = 1'b0;
    tick();
    chk("str_end", 32'(out_valid), 32'd0);
    chk("str_sc", 32'(stall_cnt), 32'd0);

    // 3: backpressure into skid
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h05;
    tick();
    chk("bp_a_od", 32'(out_data), 32'h05);
    chk("bp_a_ir", 32'(in_ready), 32'd1);
    in_data = 8'h06;
    tick();
    chk("bp_b_ir", 32'(in_ready), 32'd0);
    chk("bp_b_sc", 32'(stall_cnt), 32'd1);
    in_data = 8'h07;
    tick();
    chk("bp_c_sc", 32'(stall_cnt), 32'd2);
    chk("bp_c_od", 32'(out_data), 32'h05);
    out_ready = 1'b1;
    tick();
    chk("bp_rel_b", 32'(out_data), 32'h06);
    chk("bp_rel_ir", 32'(in_ready), 32'd1);
    tick();
    chk("bp_rel_c", 32'(out_data), 32'h07);
    chk("bp_rel_cv", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_sc_hold", 32'(stall_cnt), 32'd2);

    // 4: flush while FULL with in_valid high
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h23;
    tick();
    in_data = 8'h47;
    tick();
    chk("fl_full", 32'(in_ready), 32'd0);
    flush   = 1'b1;
    in_data = 8'h09;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_ov", 32'(out_valid), 32'd0);
    chk("fl_ir", 32'(in_ready), 32'd1);
    chk("fl_kill", 32'(out_data & 8'h03), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("fl_drop", 32'(out_valid), 32'd0);

    // 4b: flush in ONE with a real simultaneous accept
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h43;
    tick();
    chk("fl1_ov", 32'(out_valid), 32'd1);
    chk("fl1_od", 32'(out_data), 32'h43);
    flush   = 1'b1;
    in_data = 8'h09;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl1_ov2", 32'(out_valid), 32'd0);
    chk("fl1_kill", 32'(out_data & 8'h03), 32'd0);
    tick();
    chk("fl1_drop", 32'(out_valid), 32'd0);

    // 5: stall counter saturation
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h3C;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_15", 32'(stall_cnt), 32'd15);
    tick();
    tick();
    chk("sat_hold", 32'(stall_cnt), 32'd15);
    chk("sat_ov", 32'(out_valid), 32'd1);

    // 6: random traffic vs reference queue
    do_reset();
    q.delete();
    cnt_m = 0;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 99) < 5);
      in_data   = 8'($urandom);
      chk("rnd_ir", 32'(in_ready), 32'(q.size() < 2));
      chk("rnd_ov", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0)
        chk("rnd_od", 32'(out_data), 32'(q[0]));
      else
        chk("rnd_kill", 32'(out_data & 8'h03), 32'd0);
      chk("rnd_sc", 32'(stall_cnt), 32'(cnt_m));
      acc = in_valid && (q.size() < 2);
      rel = (q.size() != 0) && out_ready;
      if ((q.size() != 0) && !out_ready && cnt_m < 15)
        cnt_m++;
      if (flush) begin
        q.delete();
      end else begin
        if (rel) void'(q.pop_front());
        if (acc) q.push_back(in_data);
      end
      tick();
    end
    flush    = 1'b0;
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic, parametrised pipeline-stage register that replaces the hand-written per-stage latches (e.g. EXE→MEM).
- Carries an opaque payload bus with a valid/ready handshake.
- A two-entry skid buffer keeps in_ready registered while sustaining one transfer per cycle.
- Supports a flush that inserts a bubble, and forces side-effect control bits (write enables) to zero whenever the stage holds no valid instruction.

Parameters:
DATA_W, 64, payload width in bits (≥1).
KILL_MASK, {DATA_W{1'b0}}, bit set = payload bit is forced to 0 on out_data whenever out_valid=0 (RegWE, DataMemWE positions).
CNT_W, 16, width of the saturating stall counter.

Ports:
clk  in  1  clock, all state updates on posedge.
rst  in  1  reset.
flush  in  1  discard all held entries; the stage becomes empty next cycle.
in_valid  in  1  upstream has a payload.
in_ready  out  1  stage can accept; registered output.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  stage holds a valid payload.
out_ready  in  1  downstream accepts this cycle.
out_data  out  DATA_W  payload at head, masked per KILL_MASK when invalid.
stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Interface rule (already decided): one clock; reset is synchronous and active-high. The clock port is clk and the reset port is rst.

Behaviour:
- Storage: main register (head, drives out_data) and skid register. Each has a valid bit.
- States: EMPTY (none valid), ONE (main valid), FULL (main and skid valid). in_ready = (state != FULL), registered from next-state.
- Accept event: in_valid & in_ready. Release event: out_valid & out_ready.
- Transitions with flush=0:
  - EMPTY + accept → ONE; payload loaded into main. Latency from accept to out_valid is 1 cycle.
  - ONE + accept + release → ONE; main reloaded from in_data.
  - ONE + accept only → FULL; payload loaded into skid.
  - ONE + release only → EMPTY.
  - FULL + release → ONE; skid moves to main. No accept is possible in FULL.
  - All other combinations hold state and data.
- Order is strictly FIFO. Sustained throughput is 1/cycle when out_ready=1.
- flush=1: next state is EMPTY and in_ready=1, regardless of accept or release in the same cycle. A simultaneous accept is dropped. Data registers may keep stale contents, but KILL_MASK bits still read 0 on out_data.
- out_data = main_data & ~(out_valid ? 0 : KILL_MASK). Non-killed bits are don't-care when invalid, but the implementation holds the last value.
- stall_cnt increments on each out_valid & ~out_ready cycle and saturates at 2^CNT_W−1. It is not cleared by flush.
- rst=1 (sampled on posedge):
  - State → EMPTY; main, skid and stall_cnt → 0; out_valid=0; in_ready=1.
  - in_valid and flush are ignored that cycle.
  - Reset mid-transfer discards both entries with no partial output.
- rst has priority over flush, and flush has priority over the handshakes.

Decomposition:
- Shared package holds:
  - State encoding: ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - Per-stage payload field offsets and widths (WriteDataSrc uses WDATA_SRC_LENGTH).
  - The derived KILL_MASK constants for each stage instance (EXE_MEM_KILL etc.).
- Single module with no sub-module. Each pipeline boundary instantiates it with its own DATA_W and KILL_MASK.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with in_valid=1 → out_valid=0, out_data=0, in_ready=1, stall_cnt=0 after release.
2. Streaming: out_ready=1, push 0x11..0x18 on 8 consecutive cycles → outputs 0x11..0x18 one per cycle, first appearing 1 cycle after its accept, in_ready stays 1.
3. Backpressure/skid: out_ready=0, push A=0x5, B=0x6 → in_ready=0 after B; C held upstream; stall_cnt counts; raise out_ready → A, B, C emerge in order with no loss or duplication.
4. Flush while FULL, with a simultaneous accept of 0x9 → next cycle out_valid=0, in_ready=1, 0x9 never emerges; with KILL_MASK=0x3, out_data[1:0]=0.
5. Saturation: CNT_W=4, out_valid=1 and out_ready=0 for 20 cycles → stall_cnt=15 and holds.
6. Random valid/ready with 5% flush vs. a reference-queue scoreboard for 10k cycles → no reorder, loss or duplication; KILL bits are 0 whenever out_valid=0.
